// File: rtl/clk_div_multi_if.sv
// Control/status bundle for clk_div_multi: run enables, phase sync,
// half-period configuration writes and the per-channel outputs.
interface clk_div_multi_if #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 12,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH-1:0] en;
    logic              sync;
    logic              cfg_wr;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_half;
    logic [NUM_CH-1:0] osc;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pending;

    modport master (
        output en, sync, cfg_wr, cfg_ch, cfg_half,
        input  osc, tick, pending
    );

    modport slave (
        input  en, sync, cfg_wr, cfg_ch, cfg_half,
        output osc, tick, pending
    );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable 50%-duty square-wave generator with rise ticks,
// per-channel enable, glitch-free retune at period boundaries and phase sync.
module clk_div_multi #(
    parameter int NUM_CH       = 2,
    parameter int DIV_W        = 12,
    parameter int DEFAULT_HALF = 125
) (
    input  logic            clk,
    input  logic            reset,
    clk_div_multi_if.slave  bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [DIV_W-1:0] DEF_HALF = DIV_W'(DEFAULT_HALF);
    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] half_q, half_d;
        logic [DIV_W-1:0] pend_half_q, pend_half_d;
        logic             osc_q, osc_d;
        logic             tick_q, tick_d;
        logic             pend_q, pend_d;
        logic             term;
        logic             commit;
        logic             wr_hit;

        // Out-of-range cfg_ch never matches any channel index, so it is dropped.
        assign wr_hit = bus.cfg_wr && (bus.cfg_ch == CH_W'(c));
        assign term   = (cnt_q == (half_q - ONE));

        always_comb begin
            cnt_d       = cnt_q;
            osc_d       = osc_q;
            tick_d      = 1'b0;
            half_d      = half_q;
            pend_half_d = pend_half_q;
            pend_d      = pend_q;
            commit      = 1'b0;
            if (bus.sync || !bus.en[c]) begin
                cnt_d  = '0;
                osc_d  = 1'b1;
                commit = 1'b1;
            end else if (term) begin
                cnt_d  = '0;
                osc_d  = ~osc_q;
                tick_d = ~osc_q;
                // Retune only when a full period ends, so no phase is ever shortened.
                commit = ~osc_q;
            end else begin
                cnt_d = cnt_q + ONE;
            end
            if (commit && pend_q) begin
                half_d = pend_half_q;
                pend_d = 1'b0;
            end
            if (wr_hit) begin
                pend_half_d = (bus.cfg_half == '0) ? ONE : bus.cfg_half;
                pend_d      = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q       <= '0;
                half_q      <= DEF_HALF;
                pend_half_q <= DEF_HALF;
                osc_q       <= 1'b1;
                tick_q      <= 1'b0;
                pend_q      <= 1'b0;
            end else begin
                cnt_q       <= cnt_d;
                half_q      <= half_d;
                pend_half_q <= pend_half_d;
                osc_q       <= osc_d;
                tick_q      <= tick_d;
                pend_q      <= pend_d;
            end
        end

        assign bus.osc[c]     = osc_q;
        assign bus.tick[c]    = tick_q;
        assign bus.pending[c] = pend_q;
    end
endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: phase-position reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_clk_div_multi;
    localparam int NUM_CH = 3;
    localparam int DIV_W  = 12;
    localparam int DEF    = 125;
    localparam int CH_W   = 2;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   cmp_on = 0;

    clk_div_multi_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .CH_W(CH_W)) bus ();

    clk_div_multi #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_HALF(DEF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: position within the current period; osc is high for the first
    // half positions, and a wrap back to 0 is a rising edge.
    int m_pos  [NUM_CH];
    int m_h    [NUM_CH];
    int m_ph   [NUM_CH];
    bit m_pend [NUM_CH];
    bit m_tick [NUM_CH];

    always @(posedge clk) begin
        cyc++;
        cmp_on = 1;
        for (int c = 0; c < NUM_CH; c++) begin
            bit cm;
            cm = 0;
            m_tick[c] = 0;
            if (reset) begin
                m_pos[c]  = 0;
                m_h[c]    = DEF;
                m_ph[c]   = DEF;
                m_pend[c] = 0;
            end else begin
                if (bus.sync || !bus.en[c]) begin
                    m_pos[c] = 0;
                    cm = 1;
                end else begin
                    m_pos[c]++;
                    if (m_pos[c] == 2 * m_h[c]) begin
                        m_pos[c]  = 0;
                        m_tick[c] = 1;
                        cm = 1;
                    end
                end
                if (cm && m_pend[c]) begin
                    m_h[c]    = m_ph[c];
                    m_pend[c] = 0;
                end
                if (bus.cfg_wr && int'(bus.cfg_ch) == c) begin
                    m_ph[c]   = (bus.cfg_half == 0) ? 1 : int'(bus.cfg_half);
                    m_pend[c] = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int c = 0; c < NUM_CH; c++) begin
                bit e_osc;
                e_osc = (m_pos[c] < m_h[c]);
                checks++;
                if (bus.osc[c] !== e_osc) begin
                    errors++;
                    $display("FAIL cyc %0d osc ch%0d got=%0b want=%0b", cyc, c, bus.osc[c], e_osc);
                end
                checks++;
                if (bus.tick[c] !== m_tick[c]) begin
                    errors++;
                    $display("FAIL cyc %0d tick ch%0d got=%0b want=%0b", cyc, c, bus.tick[c], m_tick[c]);
                end
                checks++;
                if (bus.pending[c] !== m_pend[c]) begin
                    errors++;
                    $display("FAIL cyc %0d pending ch%0d got=%0b want=%0b", cyc, c, bus.pending[c], m_pend[c]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int half);
        bus.cfg_wr   = 1'b1;
        bus.cfg_ch   = CH_W'(ch);
        bus.cfg_half = DIV_W'(half);
        step(1);
        bus.cfg_wr   = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus.en       = '0;
        bus.sync     = 1'b0;
        bus.cfg_wr   = 1'b0;
        bus.cfg_ch   = '0;
        bus.cfg_half = '0;
        step(2);
        chk("reset_osc", 32'(bus.osc), 32'h7);
        chk("reset_tick", 32'(bus.tick), 32'h0);
        chk("reset_pending", 32'(bus.pending), 32'h0);

        // default half-period 125
        reset  = 1'b0;
        bus.en = 3'b111;
        step(124);
        chk("t1_osc_124", 32'(bus.osc[0]), 1);
        step(1);
        chk("t1_osc_125", 32'(bus.osc[0]), 0);
        step(124);
        chk("t1_tick_249", 32'(bus.tick[0]), 0);
        step(1);
        chk("t1_osc_250", 32'(bus.osc[0]), 1);
        chk("t1_tick_250", 32'(bus.tick[0]), 1);
        step(1);
        chk("t1_tick_251", 32'(bus.tick[0]), 0);
        step(249);
        chk("t1_tick_500", 32'(bus.tick[0]), 1);

        // half=3 / half=5, then sync
        bus.en = 3'b000;
        wr(0, 3);
        wr(1, 5);
        step(1);
        chk("t2_pending_clear", 32'(bus.pending), 32'h0);
        bus.en = 3'b111;
        step(17);
        bus.sync = 1'b1;
        step(1);
        bus.sync = 1'b0;
        chk("t2_sync_osc", 32'(bus.osc), 32'h7);
        chk("t2_sync_tick", 32'(bus.tick), 32'h0);
        step(3);
        chk("t2_fall0", 32'(bus.osc[1:0]), 32'h2);
        step(2);
        chk("t2_fall1", 32'(bus.osc[1:0]), 32'h0);
        step(1);
        chk("t2_tick0_p6", 32'(bus.tick[0]), 1);

        // mid-period retune 4 -> 2
        bus.en[0] = 1'b0;
        wr(0, 4);
        step(1);
        bus.en[0] = 1'b1;
        step(5);
        wr(0, 2);
        chk("t3_pending_set", 32'(bus.pending[0]), 1);
        step(2);
        chk("t3_commit_pending", 32'(bus.pending[0]), 0);
        chk("t3_commit_tick", 32'(bus.tick[0]), 1);
        step(2);
        chk("t3_new_fall", 32'(bus.osc[0]), 0);
        step(2);
        chk("t3_new_tick", 32'(bus.tick[0]), 1);

        // half=0 behaves as 1
        bus.en[1] = 1'b0;
        wr(1, 0);
        step(1);
        bus.en[1] = 1'b1;
        step(1);
        chk("t4_osc_a", 32'(bus.osc[1]), 0);
        step(1);
        chk("t4_osc_b", 32'(bus.osc[1]), 1);
        chk("t4_tick_b", 32'(bus.tick[1]), 1);
        step(1);
        chk("t4_osc_c", 32'(bus.osc[1]), 0);
        chk("t4_tick_c", 32'(bus.tick[1]), 0);

        // enable drop mid-low, write while disabled, re-enable
        bus.en[0] = 1'b0;
        step(1);
        bus.en[0] = 1'b1;
        step(3);
        bus.en[0] = 1'b0;
        step(1);
        chk("t5_drop_osc", 32'(bus.osc[0]), 1);
        chk("t5_drop_tick", 32'(bus.tick[0]), 0);
        wr(0, 3);
        chk("t5_wr_pending", 32'(bus.pending[0]), 1);
        step(1);
        chk("t5_commit_dis", 32'(bus.pending[0]), 0);
        bus.en[0] = 1'b1;
        step(2);
        chk("t5_reen_osc2", 32'(bus.osc[0]), 1);
        step(1);
        chk("t5_reen_osc3", 32'(bus.osc[0]), 0);

        // reset with pending, out-of-range channel write
        wr(0, 7);
        chk("t6_pending_pre", 32'(bus.pending[0]), 1);
        reset = 1'b1;
        step(1);
        chk("t6_rst_osc", 32'(bus.osc), 32'h7);
        chk("t6_rst_tick", 32'(bus.tick), 32'h0);
        chk("t6_rst_pending", 32'(bus.pending), 32'h0);
        reset  = 1'b0;
        bus.en = 3'b111;
        wr(3, 9);
        chk("t6_oor_pending", 32'(bus.pending), 32'h0);
        step(123);
        chk("t6_def_osc_124", 32'(bus.osc), 32'h7);
        step(1);
        chk("t6_def_osc_125", 32'(bus.osc), 32'h0);
        step(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
